// File: rtl/lsu_mem_stage_pkg.sv
// Shared types for the MEM-stage load/store unit: decoded control, FSM states,
// captured memory request and the funct3 load/store width codes.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
  } control_type;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_req_t;

  // A faulting instruction must never update the register file.
  function automatic control_type lsu_kill_wr(control_type c);
    control_type r;
    r           = c;
    r.reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory port: valid/ready request channel plus valid-only response channel.
interface lsu_mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic              dmem_req_we;
  logic [3:0]        dmem_req_be;
  logic [31:0]       dmem_req_wdata;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rsp_rdata;
  logic              dmem_rsp_err;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );

  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );
endinterface

// File: rtl/lsu_mem_stage_data_align.sv
// Combinational lane steering: store byte enables/data and misalignment for the
// incoming instruction, load extraction and extension for the returning word.
module lsu_mem_stage_data_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);
  logic [31:0] ld_shift;

  always_comb begin
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
    case (st_funct3_i)
      F3_B, F3_BU: begin
        st_be_o    = 4'b0001 << st_off_i;
        misalign_o = 1'b0;
      end
      F3_H, F3_HU: begin
        st_be_o    = 4'b0011 << st_off_i;
        misalign_o = st_off_i[0];
      end
      // Unknown widths behave as full words.
      default: begin
        st_be_o    = 4'b1111;
        misalign_o = |st_off_i;
      end
    endcase
  end

  always_comb begin
    ld_shift = ld_word_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_data_o = {24'h0, ld_shift[7:0]};
      F3_H:    ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data_o = {16'h0, ld_shift[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one data-memory request per memory instruction,
// stalls upstream until the response (or timeout) and fills the MEM/WB register.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic [31:0]            alu_data_in,
  input  logic [31:0]            memory_data_in,
  input  control_type            control_in,
  output logic                   stall,
  lsu_mem_stage_if.master        dmem,
  output logic                   wb_valid,
  output logic [31:0]            alu_data_out,
  output logic [31:0]            memory_data_out,
  output control_type            control_out,
  output logic                   misalign,
  output logic                   bus_err
);
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W     = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  lsu_state_e     state_q;
  lsu_req_t       req_q;
  control_type    ctrl_q;
  logic [31:0]    alu_q;
  logic [CNT_W-1:0] cnt_q;

  logic           wb_valid_q;
  logic [31:0]    wb_alu_q;
  logic [31:0]    wb_mem_q;
  control_type    wb_ctrl_q;
  logic           wb_mis_q;
  logic           wb_err_q;

  logic [3:0]     st_be;
  logic [31:0]    st_wdata;
  logic           ex_mis;
  logic [31:0]    ld_data;
  logic           mem_op;
  logic           issue;
  logic           timeout;
  logic [CNT_W:0] cnt_inc;
  lsu_req_t       req_new;
  lsu_req_t       req_cur;

  lsu_mem_stage_data_align u_align (
    .st_off_i    (alu_data_in[1:0]),
    .st_funct3_i (control_in.funct3),
    .st_data_i   (memory_data_in),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .misalign_o  (ex_mis),
    .ld_off_i    (req_q.addr[1:0]),
    .ld_funct3_i (ctrl_q.funct3),
    .ld_word_i   (dmem.dmem_rsp_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    mem_op        = ex_valid & (control_in.mem_read | control_in.mem_write);
    issue         = (state_q == LSU_IDLE) & mem_op & ~ex_mis;
    cnt_inc       = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    timeout       = (TIMEOUT != 0) && (state_q == LSU_WAIT) && (cnt_inc == TO_LIMIT);
    req_new.addr  = alu_data_in;
    req_new.we    = control_in.mem_write;
    req_new.be    = control_in.mem_write ? st_be : 4'b1111;
    req_new.wdata = st_wdata;
    // In IDLE the request goes out the same cycle, straight from EX/MEM.
    req_cur       = (state_q == LSU_IDLE) ? req_new : req_q;
  end

  assign dmem.dmem_req_valid = issue | (state_q == LSU_REQ);
  assign dmem.dmem_req_addr  = req_cur.addr[ADDR_W-1:0];
  assign dmem.dmem_req_we    = req_cur.we;
  assign dmem.dmem_req_be    = req_cur.be;
  assign dmem.dmem_req_wdata = req_cur.wdata;

  assign stall = issue | (state_q == LSU_REQ) |
                 ((state_q == LSU_WAIT) & ~dmem.dmem_rsp_valid & ~timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      req_q      <= '0;
      ctrl_q     <= '0;
      alu_q      <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_mem_q   <= '0;
      wb_ctrl_q  <= '0;
      wb_mis_q   <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      unique case (state_q)
        LSU_IDLE: begin
          if (issue) begin
            req_q   <= req_new;
            ctrl_q  <= control_in;
            alu_q   <= alu_data_in;
            cnt_q   <= '0;
            state_q <= dmem.dmem_req_ready ? LSU_WAIT : LSU_REQ;
          end else if (ex_valid) begin
            wb_valid_q <= 1'b1;
            wb_alu_q   <= alu_data_in;
            wb_mem_q   <= '0;
            wb_ctrl_q  <= (mem_op & ex_mis) ? lsu_kill_wr(control_in) : control_in;
            wb_mis_q   <= mem_op & ex_mis;
            wb_err_q   <= 1'b0;
          end
        end
        LSU_REQ: begin
          if (dmem.dmem_req_ready) begin
            cnt_q   <= '0;
            state_q <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (dmem.dmem_rsp_valid) begin
            wb_valid_q <= 1'b1;
            wb_alu_q   <= alu_q;
            wb_mem_q   <= (ctrl_q.mem_read & ~dmem.dmem_rsp_err) ? ld_data : 32'h0;
            wb_ctrl_q  <= dmem.dmem_rsp_err ? lsu_kill_wr(ctrl_q) : ctrl_q;
            wb_mis_q   <= 1'b0;
            wb_err_q   <= dmem.dmem_rsp_err;
            state_q    <= LSU_IDLE;
          end else if (timeout) begin
            wb_valid_q <= 1'b1;
            wb_alu_q   <= alu_q;
            wb_mem_q   <= '0;
            wb_ctrl_q  <= lsu_kill_wr(ctrl_q);
            wb_mis_q   <= 1'b0;
            wb_err_q   <= 1'b1;
            state_q    <= LSU_IDLE;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign wb_valid        = wb_valid_q;
  assign alu_data_out    = wb_alu_q;
  assign memory_data_out = wb_mem_q;
  assign control_out     = wb_ctrl_q;
  assign misalign        = wb_mis_q;
  assign bus_err         = wb_err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage; MEM/WB results are checked against a scoreboard
// queue filled as each instruction is driven.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] alu_data_in;
  logic [31:0] memory_data_in;
  control_type control_in;
  logic        stall;
  logic        wb_valid;
  logic [31:0] alu_data_out;
  logic [31:0] memory_data_out;
  control_type control_out;
  logic        misalign;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    control_type ctrl;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  lsu_mem_stage_if #(.ADDR_W(32)) dmem ();

  lsu_mem_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .alu_data_in     (alu_data_in),
    .memory_data_in  (memory_data_in),
    .control_in      (control_in),
    .stall           (stall),
    .dmem            (dmem),
    .wb_valid        (wb_valid),
    .alu_data_out    (alu_data_out),
    .memory_data_out (memory_data_out),
    .control_out     (control_out),
    .misalign        (misalign),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic control_type mk(logic rd, logic wr, logic [2:0] f3, logic rw);
    control_type c;
    c.mem_read  = rd;
    c.mem_write = wr;
    c.funct3    = f3;
    c.reg_write = rw;
    return c;
  endfunction

  function automatic control_type nowr(control_type c);
    control_type r;
    r = c;
    r.reg_write = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each retiring instruction must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_alu", alu_data_out, mon_e.alu);
        chk("wb_mem", memory_data_out, mon_e.mem);
        chk("wb_ctrl", 32'(control_out), 32'(mon_e.ctrl));
        chk("wb_misalign", 32'(misalign), 32'(mon_e.mis));
        chk("wb_bus_err", 32'(bus_err), 32'(mon_e.berr));
      end
    end
  end

  // Zero-wait transaction: accepted in the issue cycle, response one cycle later.
  task automatic zw_op(input control_type c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic [31:0] em, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic err);
    exp_t e;
    e.alu  = a;
    e.mem  = em;
    e.ctrl = err ? nowr(c) : c;
    e.mis  = 1'b0;
    e.berr = err;
    sb_q.push_back(e);
    ex_valid       = 1'b1;
    control_in     = c;
    alu_data_in    = a;
    memory_data_in = d;
    dmem.dmem_req_ready = 1'b1;
    #1;
    chk("zw_stall_t0", 32'(stall), 32'd1);
    chk("zw_req_valid", 32'(dmem.dmem_req_valid), 32'd1);
    chk("zw_req_we", 32'(dmem.dmem_req_we), 32'(c.mem_write));
    chk("zw_req_be", 32'(dmem.dmem_req_be), 32'(ebe));
    if (c.mem_write) chk("zw_req_wdata", dmem.dmem_req_wdata, ewd);
    tick();
    ex_valid            = 1'b0;
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rsp_rdata = rd;
    dmem.dmem_rsp_err   = err;
    #1;
    chk("zw_stall_t1", 32'(stall), 32'd0);
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_err   = 1'b0;
    #1;
    chk("zw_wb_t2", 32'(wb_valid), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    control_type lw, c;
    exp_t e;
    int nstall, nwb;

    reset = 1'b1;
    ex_valid = 1'b0;
    alu_data_in = '0;
    memory_data_in = '0;
    control_in = '0;
    dmem.dmem_req_ready = 1'b1;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = '0;
    dmem.dmem_rsp_err = 1'b0;
    repeat (3) tick();

    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_alu_out", alu_data_out, 32'd0);
    chk("rst_mem_out", memory_data_out, 32'd0);
    chk("rst_ctrl_out", 32'(control_out), 32'd0);
    chk("rst_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Stale response while idle must not retire anything.
    reset = 1'b0;
    dmem.dmem_rsp_valid = 1'b1;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    chk("stale_rsp_wb", 32'(wb_valid), 32'd0);
    tick();

    // LW 0x100, zero-wait memory.
    lw = mk(1'b1, 1'b0, F3_W, 1'b1);
    e.alu = 32'h100; e.mem = 32'hDEADBEEF; e.ctrl = lw; e.mis = 1'b0; e.berr = 1'b0;
    sb_q.push_back(e);
    ex_valid = 1'b1; control_in = lw; alu_data_in = 32'h100;
    #1;
    chk("lw_stall_t0", 32'(stall), 32'd1);
    chk("lw_req_valid_t0", 32'(dmem.dmem_req_valid), 32'd1);
    chk("lw_req_addr", dmem.dmem_req_addr, 32'h100);
    chk("lw_req_be", 32'(dmem.dmem_req_be), 32'hF);
    tick();
    ex_valid = 1'b0;
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall_t1", 32'(stall), 32'd0);
    chk("lw_wb_t1", 32'(wb_valid), 32'd0);
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    chk("lw_wb_t2", 32'(wb_valid), 32'd1);
    chk("lw_stall_t2", 32'(stall), 32'd0);
    tick();
    chk("lw_wb_pulse", 32'(wb_valid), 32'd0);

    // Byte/half lanes and extension.
    zw_op(mk(1'b0, 1'b1, F3_B, 1'b0), 32'h103, 32'h000000A5, 32'h0, 32'h0, 4'b1000, 32'hA5000000, 1'b0);
    zw_op(mk(1'b1, 1'b0, F3_B, 1'b1), 32'h103, 32'h0, 32'h80000000, 32'hFFFFFF80, 4'hF, 32'h0, 1'b0);
    zw_op(mk(1'b1, 1'b0, F3_BU, 1'b1), 32'h103, 32'h0, 32'h80000000, 32'h00000080, 4'hF, 32'h0, 1'b0);
    zw_op(mk(1'b0, 1'b1, F3_H, 1'b0), 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 4'b1100, 32'hBEEF0000, 1'b0);
    zw_op(mk(1'b1, 1'b0, F3_H, 1'b1), 32'h102, 32'h0, 32'h80011234, 32'hFFFF8001, 4'hF, 32'h0, 1'b0);
    zw_op(mk(1'b1, 1'b0, F3_HU, 1'b1), 32'h102, 32'h0, 32'hABCD1234, 32'h0000ABCD, 4'hF, 32'h0, 1'b0);
    zw_op(mk(1'b1, 1'b0, 3'b111, 1'b1), 32'h104, 32'h0, 32'h13579BDF, 32'h13579BDF, 4'hF, 32'h0, 1'b0);
    // Memory-side error: no data, no register write.
    zw_op(lw, 32'h500, 32'h0, 32'h11111111, 32'h0, 4'hF, 32'h0, 1'b1);

    // Misaligned LH: no request, retires next cycle with the fault flag.
    c = mk(1'b1, 1'b0, F3_H, 1'b1);
    e.alu = 32'h101; e.mem = 32'h0; e.ctrl = nowr(c); e.mis = 1'b1; e.berr = 1'b0;
    sb_q.push_back(e);
    ex_valid = 1'b1; control_in = c; alu_data_in = 32'h101;
    #1;
    chk("mis_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("mis_wb", 32'(wb_valid), 32'd1);
    tick();

    // Non-memory op passes straight through.
    c = mk(1'b0, 1'b0, F3_H, 1'b1);
    e.alu = 32'h55; e.mem = 32'h0; e.ctrl = c; e.mis = 1'b0; e.berr = 1'b0;
    sb_q.push_back(e);
    ex_valid = 1'b1; control_in = c; alu_data_in = 32'h55;
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
    tick();
    ex_valid = 1'b0;
    tick();

    // SW with ready low for 3 cycles and 2 empty WAIT cycles before the response.
    c = mk(1'b0, 1'b1, F3_W, 1'b0);
    e.alu = 32'h200; e.mem = 32'h0; e.ctrl = c; e.mis = 1'b0; e.berr = 1'b0;
    sb_q.push_back(e);
    nstall = 0;
    nwb = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      ex_valid = 1'b1;
      if (cyc == 0) begin
        control_in = c; alu_data_in = 32'h200; memory_data_in = 32'h12345678;
      end else begin
        control_in = mk(1'b1, 1'b0, F3_B, 1'b1);
        alu_data_in = 32'hFFFFFFF0; memory_data_in = 32'hCAFEF00D;
      end
      dmem.dmem_req_ready = (cyc == 3);
      dmem.dmem_rsp_valid = (cyc == 6);
      dmem.dmem_rsp_rdata = 32'h77777777;
      #1;
      if (stall) nstall++;
      if (wb_valid) nwb++;
      chk("sw_req_valid", 32'(dmem.dmem_req_valid), 32'(cyc <= 3));
      if (cyc <= 3) begin
        chk("sw_req_addr", dmem.dmem_req_addr, 32'h200);
        chk("sw_req_wdata", dmem.dmem_req_wdata, 32'h12345678);
        chk("sw_req_be", 32'(dmem.dmem_req_be), 32'hF);
        chk("sw_req_we", 32'(dmem.dmem_req_we), 32'd1);
      end
      tick();
    end
    ex_valid = 1'b0;
    dmem.dmem_req_ready = 1'b1;
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    if (wb_valid) nwb++;
    tick();
    if (wb_valid) nwb++;
    chk("sw_stall_cycles", 32'(nstall), 32'd6);
    chk("sw_wb_count", 32'(nwb), 32'd1);

    // No response: timeout after 4 WAIT cycles.
    e.alu = 32'h300; e.mem = 32'h0; e.ctrl = nowr(lw); e.mis = 1'b0; e.berr = 1'b1;
    sb_q.push_back(e);
    ex_valid = 1'b1; control_in = lw; alu_data_in = 32'h300;
    #1;
    chk("to_stall_t0", 32'(stall), 32'd1);
    tick();
    ex_valid = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      #1;
      chk("to_stall_wait", 32'(stall), 32'(cyc < 4));
      chk("to_wb_early", 32'(wb_valid), 32'd0);
      tick();
    end
    #1;
    chk("to_wb", 32'(wb_valid), 32'd1);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    tick();
    // FSM back in IDLE: the next op issues immediately.
    zw_op(lw, 32'h308, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);

    // Reset during WAIT abandons the load; the late response is ignored.
    ex_valid = 1'b1; control_in = lw; alu_data_in = 32'h400;
    tick();
    ex_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 32'h99999999;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      chk("rstw_wb", 32'(wb_valid), 32'd0);
      chk("rstw_stall", 32'(stall), 32'd0);
      chk("rstw_req_valid", 32'(dmem.dmem_req_valid), 32'd0);
      chk("rstw_alu_out", alu_data_out, 32'd0);
      chk("rstw_mem_out", memory_data_out, 32'd0);
      chk("rstw_ctrl_out", 32'(control_out), 32'd0);
      chk("rstw_bus_err", 32'(bus_err), 32'd0);
      tick();
      dmem.dmem_rsp_valid = 1'b0;
    end
    zw_op(lw, 32'h404, 32'h0, 32'h00001234, 32'h00001234, 4'hF, 32'h0, 1'b0);

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
